vga_pattern_sequencer: RTL and testbench
========================================

Name: vga_pattern_sequencer

Overview:
Frame-synchronous pattern scheduler and pixel generator that sits between the VGA timing counters and the colour output pins. It selects one of four test patterns, advances through them automatically every N frames or on a button request, and applies every configuration change only at the start of vertical blanking so no frame tears. Pixel colour is registered, giving one cycle of latency relative to the incoming counters.

Parameters:
H_ACTIVE, 1920, visible pixels per line
V_ACTIVE, 1080, visible lines per frame
CNT_W, 12, width of the h/v counter inputs
FRAMES_PER_PATTERN, 120, frames each pattern is held in auto mode (≥1)

Ports:
clk_148Mhz  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
video_on  in  1  high during the active area (from the timing generator)
h_count_reg  in  CNT_W  current horizontal pixel count
v_count_reg  in  CNT_W  current vertical line count
sw  in  12  solid colour {R[11:8],G[7:4],B[3:0]}; sw[3:0] is also the gradient blue
btn_next  in  1  synchronised level; each rising edge requests the next pattern
auto_mode  in  1  1 = advance every FRAMES_PER_PATTERN frames
vgaRed  out  4  registered red
vgaGreen  out  4  registered green
vgaBlue  out  4  registered blue
pattern_id  out  2  pattern currently displayed
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Single clock domain: clk_148Mhz. Reset is asynchronous and active-low on port reset.
- Reset values:
  - all colour outputs 0
  - pattern_id = 0 (SOLID), frame_tick = 0
  - frame counter 0, pending request 0, sw_shadow = 0, btn_next edge register 0
- Frame boundary: the single cycle where h_count_reg==0 and v_count_reg==V_ACTIVE. On that cycle frame_tick is registered high and appears on the next cycle, for exactly one cycle.
- Pattern state (2-bit): SOLID(0) → BARS(1) → CHECKER(2) → GRADIENT(3) → SOLID, wrapping after 3.
- Advance request:
  - A btn_next rising edge (btn_next & ~btn_prev) sets pending.
  - Extra edges while pending is set are absorbed, so at most one advance per frame.
- Auto mode:
  - At each boundary with auto_mode=1, frame_cnt increments.
  - When frame_cnt==FRAMES_PER_PATTERN-1, an auto advance fires and frame_cnt clears to 0.
  - With auto_mode=0, frame_cnt holds at 0.
- At a frame boundary, if pending or an auto advance fires:
  - pattern advances by exactly one, even when both are true on the same boundary.
  - pending clears and frame_cnt clears.
- If a btn edge and the boundary coincide, the edge counts toward this boundary.
- sw_shadow <= sw only at a frame boundary; pattern generation uses sw_shadow only.
- Pixel functions (comb), evaluated on the inputs of cycle t, registered to the outputs at t+1:
  - SOLID: sw_shadow.
  - BARS: 8 vertical bars, width H_ACTIVE/8 (integer). Index from h_count_reg; colours in order white, yellow, cyan, green, magenta, red, blue, black. Full-scale channels are 4'hF, absent channels 0.
  - CHECKER: h_count_reg[6]^v_count_reg[6] ? 12'hFFF : 12'h000.
  - GRADIENT: R = h_count_reg[10:7], G = v_count_reg[10:7], B = sw_shadow[3:0].
- Blanking: if video_on=0 at cycle t, the outputs are 0 at t+1.
- Latency: 1 cycle. The top level delays hsync/vsync by one register to stay aligned.
- Reset mid-frame: outputs are forced to 0 immediately (asynchronously). After release, the display restarts on SOLID with sw_shadow=0 until the next boundary.

Optional Feature:
- Macro: VGA_OSD_BORDER_EN.
- Defined: a 1-pixel white (12'hFFF) border overrides the pattern when video_on and (h==0 or h==H_ACTIVE-1 or v==0 or v==V_ACTIVE-1). Latency is unchanged.
- Undefined: no border logic; the pattern is shown to the edges.

Decomposition:
- Package vga_pkg:
  - pattern enum (PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_GRADIENT)
  - 12-bit rgb444 typedef
  - 1080p timing constants
  - bar colour table constant
- One sub-module, vga_bar_gen: combinational h_count → rgb444 bar colour, parameterised by H_ACTIVE.

Test Plan:
1. Reset low mid-line, then release; sw=12'hA5C, video_on=1 → colour 0 until the first boundary. Next frame shows R=A, G=5, B=C; pattern_id=0.
2. Pulse btn_next mid-frame (auto_mode=0) → pattern_id stays 0 until h=0,v=1080, then becomes 1. At h=0 in the next active frame the output is white; at h=240 it is yellow (one-cycle lag).
3. Three btn_next edges within one frame → exactly one advance. Four single-edge frames wrap pattern_id 3→0.
4. auto_mode=1, FRAMES_PER_PATTERN=2 → pattern_id changes every 2 frame_ticks. A btn edge in the expiring frame still yields a single advance, and frame_cnt restarts at 0.
5. CHECKER with video_on=0 for h≥1920 → output 0 one cycle after video_on falls. At h=64,v=0 the output is FFF; at h=64,v=64 it is 000.
6. VGA_OSD_BORDER_EN defined, GRADIENT selected → h=0 and v=1079 pixels read FFF; h=128,v=128 reads R=1, G=1, B=sw_shadow[3:0].

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern sequencer: pattern encoding,
// rgb444 pixel type, 1080p timing figures and the colour-bar palette.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID    = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

  typedef logic [11:0] rgb444_t;

  localparam int unsigned H_ACTIVE_1080P = 1920;
  localparam int unsigned V_ACTIVE_1080P = 1080;
  localparam int unsigned H_TOTAL_1080P  = 2200;
  localparam int unsigned V_TOTAL_1080P  = 1125;

  // Left-to-right: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb444_t BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic pattern_e next_pattern(input pattern_e p);
    return pattern_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/vga_bar_gen.sv
// Combinational colour-bar lookup: eight equal-width vertical bars across the
// active width; columns past the last bar stay on the final (black) bar.
module vga_bar_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int CNT_W    = 12
) (
  input  logic [CNT_W-1:0] i_h_count,
  output rgb444_t          o_rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0] w_idx_full;
  logic [2:0]       w_idx;

  always_comb begin
    w_idx_full = i_h_count / CNT_W'(BAR_W);
    w_idx      = (w_idx_full > CNT_W'(7)) ? 3'd7 : w_idx_full[2:0];
    o_rgb      = BAR_COLOURS[w_idx];
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern scheduler and registered pixel generator.
// Optional white 1-pixel OSD border when VGA_OSD_BORDER_EN is defined.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE           = H_ACTIVE_1080P,
  parameter int V_ACTIVE           = V_ACTIVE_1080P,
  parameter int CNT_W              = 12,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic             clk_148Mhz,
  input  logic             reset,
  input  logic             video_on,
  input  logic [CNT_W-1:0] h_count_reg,
  input  logic [CNT_W-1:0] v_count_reg,
  input  logic [11:0]      sw,
  input  logic             btn_next,
  input  logic             auto_mode,
  output logic [3:0]       vgaRed,
  output logic [3:0]       vgaGreen,
  output logic [3:0]       vgaBlue,
  output logic [1:0]       pattern_id,
  output logic             frame_tick
);

  localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);

  pattern_e        r_pattern;
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_pending;
  rgb444_t         r_sw_shadow;
  logic            r_btn_prev;
  logic            r_frame_tick;
  rgb444_t         r_rgb;

  logic    w_boundary;
  logic    w_btn_edge;
  logic    w_auto_fire;
  logic    w_advance;
  rgb444_t w_bar_rgb;
  rgb444_t w_pixel;

  assign w_boundary  = (h_count_reg == '0) && (v_count_reg == CNT_W'(V_ACTIVE));
  assign w_btn_edge  = btn_next & ~r_btn_prev;
  assign w_auto_fire = auto_mode && (r_frame_cnt == FC_LAST);
  // An edge landing on the boundary cycle itself counts toward this boundary
  assign w_advance   = r_pending | w_btn_edge | w_auto_fire;

  vga_bar_gen #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_bar_gen (
    .i_h_count (h_count_reg),
    .o_rgb     (w_bar_rgb)
  );

  always_comb begin
    w_pixel = '0;
    unique case (r_pattern)
      PAT_SOLID:    w_pixel = r_sw_shadow;
      PAT_BARS:     w_pixel = w_bar_rgb;
      PAT_CHECKER:  w_pixel = (h_count_reg[6] ^ v_count_reg[6]) ? 12'hFFF : 12'h000;
      PAT_GRADIENT: w_pixel = {h_count_reg[10:7], v_count_reg[10:7], r_sw_shadow[3:0]};
      default:      w_pixel = '0;
    endcase
`ifdef VGA_OSD_BORDER_EN
    if ((h_count_reg == '0) || (h_count_reg == CNT_W'(H_ACTIVE - 1)) ||
        (v_count_reg == '0) || (v_count_reg == CNT_W'(V_ACTIVE - 1)))
      w_pixel = 12'hFFF;
`endif
  end

  always_ff @(posedge clk_148Mhz or negedge reset) begin
    if (!reset) begin
      r_pattern    <= PAT_SOLID;
      r_frame_cnt  <= '0;
      r_pending    <= 1'b0;
      r_sw_shadow  <= '0;
      r_btn_prev   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_rgb        <= '0;
    end else begin
      r_btn_prev   <= btn_next;
      r_frame_tick <= w_boundary;
      r_rgb        <= video_on ? w_pixel : '0;
      // Configuration only changes here, at the start of vertical blanking
      if (w_boundary) begin
        r_sw_shadow <= sw;
        r_pending   <= 1'b0;
        if (w_advance)
          r_pattern <= next_pattern(r_pattern);
        if (w_advance || !auto_mode)
          r_frame_cnt <= '0;
        else
          r_frame_cnt <= r_frame_cnt + 1'b1;
      end else if (w_btn_edge) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign vgaRed     = r_rgb[11:8];
  assign vgaGreen   = r_rgb[7:4];
  assign vgaBlue    = r_rgb[3:0];
  assign pattern_id = r_pattern;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer: directed counter vectors push
// hand-computed expectations; a monitor pops one entry per registered output.
module tb_vga_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        von;
  logic [11:0] h, v, sw;
  logic        btn, auto_m;
  logic [3:0]  r, g, b;
  logic [1:0]  pid;
  logic        tick;

  always #5 clk = ~clk;

`ifdef VGA_OSD_BORDER_EN
  localparam int EXP_LEFT   = 'hFFF;
  localparam int EXP_BOTTOM = 'hFFF;
`else
  localparam int EXP_LEFT   = 'h03C;
  localparam int EXP_BOTTOM = 'h58C;
`endif

  vga_pattern_sequencer #(
    .H_ACTIVE           (1920),
    .V_ACTIVE           (1080),
    .CNT_W              (12),
    .FRAMES_PER_PATTERN (2)
  ) dut (
    .clk_148Mhz  (clk),
    .reset       (rst_n),
    .video_on    (von),
    .h_count_reg (h),
    .v_count_reg (v),
    .sw          (sw),
    .btn_next    (btn),
    .auto_mode   (auto_m),
    .vgaRed      (r),
    .vgaGreen    (g),
    .vgaBlue     (b),
    .pattern_id  (pid),
    .frame_tick  (tick)
  );

  typedef struct {
    logic [11:0] rgb;
    logic [1:0]  pid;
    logic        tick;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs registered at this edge belong to the oldest entry
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ".rgb"},  {r, g, b}, e.rgb);
      check({e.name, ".pid"},  pid,       e.pid);
      check({e.name, ".tick"}, tick,      e.tick);
    end
  end

  task automatic drive(input int hh, input int vv, input bit vo, input bit bt,
                       input int exp_rgb, input int exp_pid, input bit exp_tick,
                       input string name);
    exp_t e;
    @(negedge clk);
    h   = 12'(hh);
    v   = 12'(vv);
    von = vo;
    btn = bt;
    e.rgb  = 12'(exp_rgb);
    e.pid  = 2'(exp_pid);
    e.tick = exp_tick;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic frame(input bit bt, input int exp_pid, input string name);
    drive(0, 1080, 1'b0, bt, 'h000, exp_pid, 1'b1, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; von = 1'b0; h = '0; v = '0; sw = '0; btn = 1'b0; auto_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rgb",  {r, g, b}, 0);
    check("rst.pid",  pid, 0);
    check("rst.tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sw    = 12'hA5C;

    // Start-up: shadow is 0 until the first boundary
    drive(100, 5, 1, 0, 'h000, 0, 0, "t1_pre");
    drive(500, 500, 1, 0, 'h000, 0, 0, "t1_pre2");
    frame(0, 0, "t1_fb");
    drive(5, 3, 1, 0, 'hA5C, 0, 0, "t1_solid");
    drive(1000, 700, 1, 0, 'hA5C, 0, 0, "t1_solid2");
    drive(1000, 700, 0, 0, 'h000, 0, 0, "t1_blank");

    // Single button press -> BARS at the boundary
    drive(300, 300, 1, 1, 'hA5C, 0, 0, "t2_btn");
    drive(301, 300, 1, 0, 'hA5C, 0, 0, "t2_hold");
    frame(0, 1, "t2_fb");
    drive(0, 0, 1, 0, 'hFFF, 1, 0, "t2_white");
    drive(240, 1, 1, 0, 'hFF0, 1, 0, "t2_yellow");
    drive(239, 1, 1, 0, 'hFFF, 1, 0, "t2_edge239");
    drive(720, 1, 1, 0, 'h0F0, 1, 0, "t2_green");
    drive(960, 500, 1, 0, 'hF0F, 1, 0, "t2_magenta");
    drive(1680, 1, 1, 0, 'h000, 1, 0, "t2_black");

    // Three edges in one frame -> one advance; then wrap 3 -> 0
    drive(100, 100, 1, 1, 'hFFF, 1, 0, "t3_e1");
    drive(101, 100, 1, 0, 'hFFF, 1, 0, "t3_e1l");
    drive(102, 100, 1, 1, 'hFFF, 1, 0, "t3_e2");
    drive(103, 100, 1, 0, 'hFFF, 1, 0, "t3_e2l");
    drive(104, 100, 1, 1, 'hFFF, 1, 0, "t3_e3");
    drive(105, 100, 1, 0, 'hFFF, 1, 0, "t3_e3l");
    frame(0, 2, "t3_fb");
    drive(10, 10, 1, 1, 'h000, 2, 0, "t3_chk");
    drive(11, 10, 1, 0, 'h000, 2, 0, "t3_chk2");
    frame(0, 3, "t3_fb3");
    drive(128, 128, 1, 1, 'h11C, 3, 0, "t3_grad");
    drive(129, 128, 1, 0, 'h11C, 3, 0, "t3_grad2");
    frame(0, 0, "t3_wrap");
    drive(50, 50, 1, 1, 'hA5C, 0, 0, "t3_solid");
    drive(51, 50, 1, 0, 'hA5C, 0, 0, "t3_solid2");
    frame(0, 1, "t3_fb1");
    drive(60, 60, 1, 1, 'hFFF, 1, 0, "t3_bars");
    drive(61, 60, 1, 0, 'hFFF, 1, 0, "t3_bars2");
    frame(0, 2, "t3_fb2");

    // Checker squares and blanking at the end of the line
    drive(64, 0, 1, 0, 'hFFF, 2, 0, "t5_64_0");
    drive(64, 64, 1, 0, 'h000, 2, 0, "t5_64_64");
    drive(1918, 10, 1, 0, 'hFFF, 2, 0, "t5_1918");
    drive(1920, 10, 0, 0, 'h000, 2, 0, "t5_blank0");
    drive(1921, 10, 0, 0, 'h000, 2, 0, "t5_blank1");

    // Auto mode, 2 frames per pattern
    auto_m = 1'b1;
    frame(0, 2, "t4_f1");
    drive(5, 5, 1, 0, 'h000, 2, 0, "t4_mid1");
    frame(0, 3, "t4_f2");
    drive(5, 5, 1, 0, 'h00C, 3, 0, "t4_mid2");
    frame(0, 3, "t4_f3");
    drive(5, 5, 1, 1, 'h00C, 3, 0, "t4_btn");
    drive(6, 5, 1, 0, 'h00C, 3, 0, "t4_btnl");
    frame(0, 0, "t4_both");
    drive(5, 5, 1, 0, 'hA5C, 0, 0, "t4_mid3");
    frame(0, 0, "t4_f5");
    drive(5, 5, 1, 0, 'hA5C, 0, 0, "t4_mid4");
    frame(0, 1, "t4_f6");
    drive(5, 5, 1, 0, 'hFFF, 1, 0, "t4_mid5");
    auto_m = 1'b0;

    // Edge coincident with the boundary counts once and leaves nothing pending
    frame(1, 2, "tco_fb");
    drive(5, 5, 1, 0, 'h000, 2, 0, "tco_mid");
    frame(0, 2, "tco_nopend");

    // Gradient, with border expectations where the border is built in
    drive(5, 5, 1, 1, 'h000, 2, 0, "t6_btn");
    drive(6, 5, 1, 0, 'h000, 2, 0, "t6_btnl");
    frame(0, 3, "t6_fb");
    drive(0, 500, 1, 0, EXP_LEFT, 3, 0, "t6_left");
    drive(700, 1079, 1, 0, EXP_BOTTOM, 3, 0, "t6_bottom");
    drive(128, 128, 1, 0, 'h11C, 3, 0, "t6_inner");
    sw = 12'h123;
    drive(128, 128, 1, 0, 'h11C, 3, 0, "t6_shadow_hold");
    frame(0, 3, "t6_fb2");
    drive(128, 128, 1, 0, 'h113, 3, 0, "t6_shadow_new");

    // Asynchronous reset mid-frame
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.rgb",  {r, g, b}, 0);
    check("arst.pid",  pid, 0);
    check("arst.tick", tick, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(128, 128, 1, 0, 'h000, 0, 0, "post_rst");
    frame(0, 0, "post_rst_fb");
    drive(30, 30, 1, 0, 'h123, 0, 0, "post_rst_solid");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
